// File: rtl/razor_bus_controller.sv
// Data-port bus for the razor CPU: on-chip RAM plus a 16-byte MMIO block
// (GPIO_OUT, SCRATCH, free-running CYCLE). Lane-masked writes, combinational reads.
module razor_bus_controller #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  write_mask,
  input  logic [31:0] addr,
  input  logic [31:0] d_write,
  output logic [31:0] d_read
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  localparam logic [1:0] REG_GPIO_OUT = 2'd0;
  localparam logic [1:0] REG_SCRATCH  = 2'd1;
  localparam logic [1:0] REG_CYCLE    = 2'd2;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   gpio_out_reg;
  logic [31:0]   scratch_reg;
  logic [31:0]   cycle_reg;

  logic [31:0]   ram_offset;
  logic          ram_hit;
  logic [AW-1:0] ram_index;
  logic          mmio_hit;
  logic [1:0]    reg_sel;
  logic [31:0]   bit_mask;

  // Offset is checked as unsigned, so addresses below RAM_BASE wrap to huge values and miss.
  assign ram_offset = addr - RAM_BASE;
  assign ram_hit    = (addr >= RAM_BASE) && ({1'b0, ram_offset} < RAM_BYTES);
  assign ram_index  = ram_offset[AW+1:2];
  assign mmio_hit   = (addr[31:4] == MMIO_BASE[31:4]);
  assign reg_sel    = addr[3:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign bit_mask[8*gi +: 8] = {8{write_mask[gi]}};
    end
  endgenerate

  // RAM has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (rst && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (write_mask[i]) begin
          ram[ram_index][8*i +: 8] <= d_write[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio_out_reg <= 32'h0;
      scratch_reg  <= 32'h0;
      cycle_reg    <= 32'h0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      if (mmio_hit) begin
        case (reg_sel)
          REG_GPIO_OUT: gpio_out_reg <= (gpio_out_reg & ~bit_mask) | (d_write & bit_mask);
          REG_SCRATCH:  scratch_reg  <= (scratch_reg & ~bit_mask) | (d_write & bit_mask);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    d_read = 32'h0;
    if (ram_hit) begin
      d_read = ram[ram_index];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_GPIO_OUT: d_read = gpio_out_reg;
        REG_SCRATCH:  d_read = scratch_reg;
        REG_CYCLE:    d_read = cycle_reg;
        default:      d_read = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_razor_bus_controller.sv
// Directed bench for razor_bus_controller: stimulus queues expected d_read values,
// a negedge monitor pops and compares them.
module tb_razor_bus_controller;

  localparam int RAM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  write_mask = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] d_write = 32'h0;
  logic [31:0] d_read;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  razor_bus_controller #(
    .RAM_WORDS(RAM_WORDS),
    .RAM_BASE (32'h0000_0000),
    .MMIO_BASE(32'h1000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .write_mask(write_mask),
    .addr      (addr),
    .d_write   (d_write),
    .d_read    (d_read)
  );

  always #5 clk = ~clk;

  // Each task drives one cycle just after a rising edge; the following edge applies it.
  task automatic drive(input logic r, input logic [3:0] wm, input logic [31:0] a,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    rst        = r;
    write_mask = wm;
    addr       = a;
    d_write    = d;
  endtask

  task automatic expect_now(input string tag, input logic [31:0] a, input logic [31:0] e);
    exp_t x;
    x.tag  = tag;
    x.addr = a;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
    drive(1'b1, 4'h0, a, 32'h0);
    expect_now(tag, a, e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] d);
    drive(1'b1, wm, a, d);
  endtask

  // Write cycle that also checks the pre-write value visible before the edge.
  task automatic wr_chk(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] d,
                        input logic [31:0] pre, input string tag);
    drive(1'b1, wm, a, d);
    expect_now(tag, a, pre);
  endtask

  task automatic idle();
    drive(1'b1, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_total++;
        if (d_read === x.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s addr=%h d_read=%h expected=%h", x.tag, x.addr, d_read, x.exp);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    repeat (3) @(posedge clk);

    // Reset state: rst goes high with this cycle, no rising edge with rst high yet.
    rd(32'h1000_0008, 32'h0, "rst_cycle");
    rd(32'h1000_0000, 32'h0, "rst_gpio");
    rd(32'h1000_0004, 32'h0, "rst_scratch");

    // Masked MMIO write, then mask 0 leaves it alone.
    wr(32'h1000_0000, 4'b0011, 32'hFFFF_FFFF);
    rd(32'h1000_0000, 32'h0000_FFFF, "gpio_masked");
    for (int i = 0; i < 3; i++) wr(32'h1000_0000, 4'b0000, 32'd18);
    rd(32'h1000_0000, 32'h0000_FFFF, "gpio_mask0");

    // Same-cycle read and write shows old value, then new.
    wr_chk(32'h1000_0004, 4'b1111, 32'h1234_5678, 32'h0, "rw_pre");
    rd(32'h1000_0004, 32'h1234_5678, "rw_post");

    // Reset with a write pending: write dropped, registers cleared.
    drive(1'b0, 4'b1111, 32'h1000_0000, 32'hAAAA_AAAA);
    expect_now("rst_pre_edge", 32'h1000_0000, 32'h0000_FFFF);
    rd(32'h1000_0000, 32'h0, "gpio_after_rst");
    rd(32'h1000_0004, 32'h0, "scratch_after_rst");
    idle();
    rd(32'h1000_0000, 32'h0, "gpio_still0");

    // RAM byte lanes, retained across reset.
    wr(32'h0000_0010, 4'b1111, 32'h1122_3344);
    wr(32'h0000_0010, 4'b0100, 32'hAABB_CCDD);
    rd(32'h0000_0010, 32'h11BB_3344, "ram_lanes");
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    rd(32'h0000_0010, 32'h11BB_3344, "ram_keep_rst");

    // Cycle counter: reset edge, then 10 edges with rst high.
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) idle();
    rd(32'h1000_0008, 32'd10, "cycle_10");
    wr_chk(32'h1000_0008, 4'b1111, 32'hFFFF_FFFF, 32'd11, "cycle_wr_pre");
    rd(32'h1000_0008, 32'd12, "cycle_wr_ignored");
    rd(32'h1000_0008, 32'd13, "cycle_13");

    // Unmapped addresses.
    wr_chk(32'h2000_0000, 4'b1111, 32'h0000_0055, 32'h0, "unmapped_a_pre");
    rd(32'h2000_0000, 32'h0, "unmapped_a");
    wr_chk(32'h1000_000C, 4'b1111, 32'h0000_0066, 32'h0, "unmapped_c_pre");
    rd(32'h1000_000C, 32'h0, "unmapped_c");
    rd(32'h1000_0000, 32'h0, "gpio_untouched");
    rd(32'h1000_0004, 32'h0, "scratch_untouched");
    rd(32'h0000_0010, 32'h11BB_3344, "ram_untouched");

    // Low address bits ignored.
    wr(32'h1000_0007, 4'b1111, 32'hDEAD_BEEF);
    rd(32'h1000_0004, 32'hDEAD_BEEF, "scratch_alias_wr");
    rd(32'h1000_0006, 32'hDEAD_BEEF, "scratch_alias_rd");

    // RAM boundary.
    wr(32'h0000_0000, 4'b1111, 32'h0BAD_F00D);
    wr(32'(4*RAM_WORDS-4), 4'b1111, 32'h5A5A_5A5A);
    rd(32'(4*RAM_WORDS-4), 32'h5A5A_5A5A, "ram_last");
    rd(32'(4*RAM_WORDS), 32'h0, "ram_past_end");
    wr(32'(4*RAM_WORDS), 4'b1111, 32'hFFFF_FFFF);
    rd(32'h0000_0000, 32'h0BAD_F00D, "ram_word0_safe");
    rd(32'(4*RAM_WORDS), 32'h0, "ram_past_end_wr");

    idle();
    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/razor_bus_controller.md
Name: razor_bus_controller

Overview:
- Single-master memory-mapped bus for the razor CPU data port.
- Decodes a 32-bit byte address into an on-chip data RAM and a small MMIO register block.
- Performs byte-lane-masked writes on the clock edge and returns read data combinationally on d_read.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words (power of two); RAM spans RAM_BASE to RAM_BASE + 4*RAM_WORDS - 1.
- RAM_BASE, 32'h0000_0000, byte base address of the RAM region.
- MMIO_BASE, 32'h1000_0000, byte base of the 16-byte MMIO block (16-byte aligned).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- write_mask  input  4  byte-lane write enables; bit i writes d_write[8i+7:8i]; 4'b0000 = read/idle.
- addr  input  32  byte address; addr[1:0] ignored (word-aligned access).
- d_write  input  32  write data.
- d_read  output  32  read data for addr, combinational.

Behaviour:
- Decode:
  - RAM hit when RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS; word index = (addr - RAM_BASE) >> 2.
  - MMIO hit when addr[31:4] == MMIO_BASE[31:4]; register offset = addr[3:2].
  - Anything else is unmapped.
- MMIO map:
  - offset 0x0 GPIO_OUT: read/write, byte-maskable.
  - offset 0x4 SCRATCH: read/write, byte-maskable.
  - offset 0x8 CYCLE: read-only free-running 32-bit counter.
  - offset 0xC: unmapped.
- Writes:
  - On a rising edge with rst high and write_mask != 0, each enabled lane of the addressed word/register is updated from d_write.
  - Disabled lanes keep their old value.
  - write_mask == 0 never modifies state, whatever d_write is.
- Reads:
  - d_read = current stored value at addr (RAM word, register, or counter), purely combinational, zero-cycle latency.
  - Unmapped reads return 32'h0000_0000; unmapped writes are silently dropped.
- Same-cycle read and write to one address: d_read shows the pre-write value until the edge, then the new value.
- CYCLE:
  - Increments by 1 every rising edge while rst is high.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Writes to CYCLE are ignored; counting continues.
- Reset (rst low at a rising edge):
  - GPIO_OUT, SCRATCH and CYCLE are cleared to 0.
  - All writes in that cycle are ignored.
  - RAM contents are retained, not cleared.
  - d_read has no separate reset value; it always reflects current state, so MMIO reads return 0 right after reset.
- Reset asserted mid-sequence: takes effect at the next edge regardless of write_mask; the bus resumes normal operation on the first edge with rst high.
- No handshake, wait states or error signalling; every access completes in one cycle.

Test Plan:
- Masked MMIO write:
  - rst high; addr=0x1000_0000, write_mask=4'b0011, d_write=0xFFFF_FFFF, one edge -> d_read=0x0000_FFFF.
  - Then write_mask=0, d_write=18 for several edges -> d_read stays 0x0000_FFFF.
- Reset clears MMIO:
  - After the previous scenario, hold rst low for one edge -> d_read at 0x1000_0000 = 0.
  - Release rst -> GPIO_OUT still 0 until a new write.
- RAM byte lanes:
  - Write 0x1122_3344 mask 4'b1111 to 0x0000_0010, then 0xAABB_CCDD mask 4'b0100 -> read 0x0000_0010 = 0x11BB_3344.
  - Pulse rst low -> still 0x11BB_3344.
- Cycle counter:
  - Release reset, wait 10 edges -> read 0x1000_0008 = 10.
  - Write 0xFFFF_FFFF to it -> next read continues counting (11, 12, ...), not 0xFFFF_FFFF.
- Unmapped and ignored addr bits:
  - Write to 0x2000_0000 and 0x1000_000C -> both read 0 and no other register changes.
  - Write SCRATCH via 0x1000_0007 mask 4'b1111 data 0xDEAD_BEEF -> read at 0x1000_0004 = 0xDEAD_BEEF.
- RAM boundary:
  - Write the last word 4*RAM_WORDS-4 with 0x5A5A_5A5A -> read back 0x5A5A_5A5A.
  - Address 4*RAM_WORDS reads 0; a write to it does not alter word 0.
